// File: rtl/spi_regbank_pkg.sv
// Shared types and frame-format constants for the spi_regbank SPI slave.
package spi_regbank_pkg;

  localparam int CMD_W        = 8;
  localparam int ADDR_FIELD_W = 7;
  localparam int RW_BIT       = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/spi_regbank_if.sv
// SPI pin bundle between an SPI master and the spi_regbank slave.
interface spi_regbank_if;
  // Mode 0, MSB first: the master drives mosi and samples miso on sclk rise;
  // the slave updates miso on sclk fall. A frame lasts while cs_n is low.
  logic sclk;
  logic cs_n;
  logic mosi;
  logic miso;
  logic miso_oe;

  modport master (output sclk, output cs_n, output mosi, input miso, input miso_oe);
  modport slave  (input sclk, input cs_n, input mosi, output miso, output miso_oe);
endinterface

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for an asynchronous pin followed by a registered
// rise/fall detector; edges appear 3 clk after the pin changes.
module spi_sync_edge #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;
  logic r_rise;
  logic r_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
      r_prev <= RESET_VAL;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
      r_rise <= r_sync & ~r_prev;
      r_fall <= ~r_sync & r_prev;
    end
  end

  assign o_rise = r_rise;
  assign o_fall = r_fall;

endmodule

// File: rtl/spi_regbank.sv
// Oversampled SPI slave writing a bank of NREGS x WIDTH control registers.
// Define SPI_REGBANK_READBACK_EN to build register readback over miso.
module spi_regbank
  import spi_regbank_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               NREGS       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  spi_regbank_if.slave           spi,
  output logic [NREGS*WIDTH-1:0] reg_out,
  output logic [NREGS-1:0]       wr_strobe,
  output state_t                 o_dbg_state
);

  localparam int CNT_W = $clog2(((WIDTH > CMD_W) ? WIDTH : CMD_W) + 1);

  logic w_sclk_rise, w_sclk_fall, w_cs_rise, w_cs_fall;
  logic r_mosi_meta, r_mosi_sync, r_mosi_d;

  state_t                   r_state, w_state_next;
  logic                     w_cmd_done, w_data_done, w_commit;
  logic [CNT_W-1:0]         r_bit_cnt;
  logic [CMD_W-2:0]         r_cmd_sh;
  logic [CMD_W-1:0]         r_cmd, w_cmd_full;
  logic [WIDTH-1:0]         r_data_sh, w_data_full;
  logic [ADDR_FIELD_W-1:0]  w_addr;
  logic [NREGS*WIDTH-1:0]   r_reg_flat;
  logic [NREGS-1:0]         r_wr_strobe, w_strobe_next;

  spi_sync_edge #(.RESET_VAL(1'b0)) u_sclk_sync (
    .clk(clk), .rst_n(rst_n), .i_async(spi.sclk), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
  );

  spi_sync_edge #(.RESET_VAL(1'b1)) u_cs_sync (
    .clk(clk), .rst_n(rst_n), .i_async(spi.cs_n), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
  );

  // Three stages so the sampled mosi lines up with the registered sclk rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mosi_meta <= 1'b0;
      r_mosi_sync <= 1'b0;
      r_mosi_d    <= 1'b0;
    end else begin
      r_mosi_meta <= spi.mosi;
      r_mosi_sync <= r_mosi_meta;
      r_mosi_d    <= r_mosi_sync;
    end
  end

  assign w_cmd_full  = {r_cmd_sh, r_mosi_d};
  assign w_data_full = (r_data_sh << 1) | WIDTH'(r_mosi_d);
  assign w_addr      = r_cmd[ADDR_FIELD_W-1:0];
  assign w_commit    = w_data_done && !r_cmd[RW_BIT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // A cs_n rise beats a simultaneous final sclk rise, so partial frames never commit.
  always_comb begin
    w_state_next = r_state;
    w_cmd_done   = 1'b0;
    w_data_done  = 1'b0;
    if (w_cs_rise) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE: if (w_cs_fall) w_state_next = CMD;
        CMD: begin
          if (w_sclk_rise && r_bit_cnt == CNT_W'(CMD_W - 1)) begin
            w_state_next = DATA;
            w_cmd_done   = 1'b1;
          end
        end
        DATA: begin
          if (w_sclk_rise && r_bit_cnt == CNT_W'(WIDTH - 1)) begin
            w_state_next = DONE;
            w_data_done  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_strobe_next = '0;
    for (int i = 0; i < NREGS; i++)
      w_strobe_next[i] = w_commit && (w_addr == ADDR_FIELD_W'(i));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt   <= '0;
      r_cmd_sh    <= '0;
      r_cmd       <= '0;
      r_data_sh   <= '0;
      r_reg_flat  <= {NREGS{RESET_VALUE}};
      r_wr_strobe <= '0;
    end else begin
      r_wr_strobe <= w_strobe_next;
      for (int i = 0; i < NREGS; i++)
        if (w_strobe_next[i]) r_reg_flat[i*WIDTH +: WIDTH] <= w_data_full;
      if (r_state == IDLE || w_state_next != r_state)
        r_bit_cnt <= '0;
      else if (w_sclk_rise && (r_state == CMD || r_state == DATA))
        r_bit_cnt <= r_bit_cnt + 1'b1;
      if (r_state == CMD && w_sclk_rise) r_cmd_sh <= w_cmd_full[CMD_W-2:0];
      if (w_cmd_done) r_cmd <= w_cmd_full;
      if (r_state == DATA && w_sclk_rise) r_data_sh <= w_data_full;
    end
  end

`ifdef SPI_REGBANK_READBACK_EN
  logic [WIDTH-1:0] r_rd_sh, w_rd_val;
  logic             r_miso, r_miso_oe, w_rd_next;

  always_comb begin
    w_rd_val = '0;
    for (int i = 0; i < NREGS; i++)
      if (w_cmd_full[ADDR_FIELD_W-1:0] == ADDR_FIELD_W'(i)) w_rd_val = r_reg_flat[i*WIDTH +: WIDTH];
  end

  assign w_rd_next = w_cmd_done ? w_cmd_full[RW_BIT] : r_cmd[RW_BIT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_sh   <= '0;
      r_miso    <= 1'b0;
      r_miso_oe <= 1'b0;
    end else begin
      r_miso_oe <= (w_state_next == DATA) && w_rd_next;
      if (w_cmd_done) begin
        r_rd_sh <= w_cmd_full[RW_BIT] ? w_rd_val : '0;
      end else if (r_state == DATA && r_cmd[RW_BIT] && w_sclk_fall && !w_cs_rise) begin
        r_miso  <= r_rd_sh[WIDTH-1];
        r_rd_sh <= r_rd_sh << 1;
      end
      if (w_cs_rise) r_miso <= 1'b0;
    end
  end

  assign spi.miso    = r_miso;
  assign spi.miso_oe = r_miso_oe;
`else
  // sclk falls only matter when miso is driven.
  logic w_unused;
  assign w_unused    = w_sclk_fall;
  assign spi.miso    = 1'b0;
  assign spi.miso_oe = 1'b0;
`endif

  assign reg_out     = r_reg_flat;
  assign wr_strobe   = r_wr_strobe;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_spi_regbank.sv
// Self-checking bench for spi_regbank: directed frames plus randomized traffic
// scored against a register-array model of the SPI frame rules.
module tb_spi_regbank;
  import spi_regbank_pkg::*;

  localparam int W = 8;
  localparam int N = 4;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N*W-1:0] reg_out;
  logic [N-1:0]   wr_strobe;
  state_t         dbg_state;

  spi_regbank_if spi_if();

  spi_regbank #(.WIDTH(W), .NREGS(N), .RESET_VALUE(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .spi(spi_if),
    .reg_out(reg_out), .wr_strobe(wr_strobe), .o_dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [W-1:0] model_regs [N];
  logic [W-1:0] exp_q [$];
  int mon_addr;
  logic [W-1:0] tb_rd;
  int tb_oe;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [N*W-1:0] model_flat();
    logic [N*W-1:0] f;
    for (int i = 0; i < N; i++) f[i*W +: W] = model_regs[i];
    return f;
  endfunction

  // Every strobe must match the next expected write, last exactly one clk
  // (a longer pulse pops a second, absent entry) and carry the new value.
  always @(negedge clk) begin
    if (rst_n && wr_strobe != '0) begin
      if (exp_q.size() == 0) begin
        check("wr_strobe_unexpected", 32'(wr_strobe), 32'd0);
      end else begin
        mon_addr = int'(exp_q.pop_front());
        check("wr_strobe_onehot", 32'(wr_strobe), 32'd1 << mon_addr);
        check("wr_slot_value", 32'(reg_out[mon_addr*W +: W]), 32'(model_regs[mon_addr]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // One mode-0 frame: 8 command bits then ndata data bits, half period 4 clk.
  // rst_bit >= 0 pulses rst_n while sclk is high on that bit.
  task automatic spi_frame(input logic [7:0] cmd, input logic [W-1:0] data, input int ndata,
                           input int rst_bit, output logic [W-1:0] rd, output int oe_cnt);
    logic [15:0] bits;
    bits   = {cmd, data};
    rd     = '0;
    oe_cnt = 0;
    spi_if.cs_n = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 8 + ndata; i++) begin
      spi_if.mosi = bits[15-i];
      repeat (4) @(negedge clk);
      spi_if.sclk = 1'b1;
      repeat (2) @(negedge clk);
      if (i >= 8) begin
        rd = {rd[W-2:0], spi_if.miso};
        if (spi_if.miso_oe) oe_cnt++;
      end
      if (i == rst_bit) begin
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
      repeat (2) @(negedge clk);
      spi_if.sclk = 1'b0;
    end
    repeat (4) @(negedge clk);
    spi_if.cs_n = 1'b1;
    spi_if.mosi = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic do_write(input int addr, input logic [W-1:0] data, input int ndata);
    logic [W-1:0] rd;
    int oe;
    if (ndata == W && addr < N) begin
      model_regs[addr] = data;
      exp_q.push_back(W'(addr));
    end
    spi_frame({1'b0, 7'(addr)}, data, ndata, -1, rd, oe);
    check("regs_after_write", reg_out, model_flat());
    check("strobe_drained", exp_q.size(), 0);
  endtask

  task automatic do_read(input int addr);
    logic [W-1:0] rd, exp_rd;
    int oe, exp_oe;
    spi_frame({1'b1, 7'(addr)}, W'($urandom), W, -1, rd, oe);
`ifdef SPI_REGBANK_READBACK_EN
    exp_rd = (addr < N) ? model_regs[addr] : '0;
    exp_oe = W;
`else
    exp_rd = '0;
    exp_oe = 0;
`endif
    check("read_data", rd, exp_rd);
    check("read_oe_bits", oe, exp_oe);
    check("regs_after_read", reg_out, model_flat());
    check("miso_idle", spi_if.miso, 1'b0);
    check("miso_oe_idle", spi_if.miso_oe, 1'b0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int addr, ndata;
    logic [W-1:0] data;
    spi_if.sclk = 1'b0;
    spi_if.cs_n = 1'b1;
    spi_if.mosi = 1'b0;
    for (int i = 0; i < N; i++) model_regs[i] = '0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    check("reset_reg_out", reg_out, 32'h0);
    check("reset_wr_strobe", 32'(wr_strobe), 32'h0);
    check("reset_miso", spi_if.miso, 1'b0);
    check("reset_miso_oe", spi_if.miso_oe, 1'b0);
    check("reset_state", 32'(dbg_state), 32'(IDLE));

    do_write(2, 8'hA5, W);
    check("slot2_a5", 32'(reg_out[23:16]), 32'hA5);
    do_write(1, 8'h3C, W);
    do_read(1);
    do_write(5, 8'hFF, W);
    do_read(5);
    do_read(2);

    do_write(0, 8'h6B, 5);
    check("partial_slot0", 32'(reg_out[7:0]), 32'h00);
    do_write(0, 8'h11, W);

    do_write(3, 8'h77, W);
    for (int i = 0; i < N; i++) model_regs[i] = '0;
    spi_frame(8'h01, 8'h99, W, 10, tb_rd, tb_oe);
    check("midreset_regs", reg_out, 32'h0);
    check("midreset_state", 32'(dbg_state), 32'(IDLE));
    do_write(2, 8'h5A, W);
    do_read(2);

    for (int k = 0; k < 24; k++) begin
      addr  = int'($urandom_range(0, 5));
      data  = W'($urandom_range(0, 255));
      ndata = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, W - 1)) : W;
      if ($urandom_range(0, 2) == 0) do_read(addr);
      else do_write(addr, data, ndata);
    end

    repeat (10) @(negedge clk);
    check("strobe_pending", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
